// File: rtl/fc_layer_pkg.sv
// Shared types and widths for the fully-connected classifier layer.
package fc_layer_pkg;

  localparam int unsigned FEATURE_W = 22;
  localparam int unsigned WEIGHT_W  = 8;
  localparam int unsigned BIAS_W    = 16;
  localparam int unsigned ACC_W     = 38;
  localparam int unsigned PROD_W    = FEATURE_W + WEIGHT_W;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BIAS_BASE = 900;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    BIAS,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/fc_mac.sv
// One neuron: local weight/bias storage, registered product and wide accumulator.
module fc_mac
  import fc_layer_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = 225,
  parameter int unsigned IDX_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_we,
  input  logic [IDX_W-1:0]            w_idx,
  input  logic signed [WEIGHT_W-1:0]  w_data,
  input  logic                        b_we,
  input  logic signed [BIAS_W-1:0]    b_data,
  input  logic                        clear,
  input  logic                        en,
  input  logic [IDX_W-1:0]            idx,
  input  logic signed [FEATURE_W-1:0] feature,
  input  logic                        add_bias,
  output logic signed [ACC_W-1:0]     acc
);

  logic signed [WEIGHT_W-1:0] weight [NUM_FEATURES];
  logic signed [BIAS_W-1:0]   bias;
  logic signed [PROD_W-1:0]   prod;
  logic                       prod_valid;

  // Parameter storage is deliberately not reset so it survives across frames and resets.
  always_ff @(posedge clk) begin
    if (w_we) weight[w_idx] <= w_data;
    if (b_we) bias <= b_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      prod_valid <= en;
      if (en) prod <= PROD_W'(feature) * PROD_W'(weight[idx]);
      acc <= acc + (prod_valid ? ACC_W'(prod) : '0) + (add_bias ? ACC_W'(bias) : '0);
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer after pooling: per-frame dot products, bias, streamed results and argmax.
module fc_layer
  import fc_layer_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = 225,
  parameter int unsigned NUM_NEURONS  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_signal,
  input  logic                        feature_valid,
  input  logic signed [FEATURE_W-1:0] feature_in,
  input  logic                        w_we,
  input  logic [ADDR_W-1:0]           w_addr,
  input  logic [DATA_W-1:0]           w_data,
  output logic signed [ACC_W-1:0]     result_out,
  output logic                        result_valid,
  output logic [1:0]                  class_out,
  output logic                        class_valid,
  output logic                        done_signal
);

  localparam int unsigned IDX_W = $clog2(NUM_FEATURES + 1);
  localparam int unsigned K_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  state_t state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [K_W-1:0]          out_k;
  logic [K_W-1:0]          best_idx;
  logic signed [ACC_W-1:0] best_val;
  logic signed [ACC_W-1:0] acc [NUM_NEURONS];

  logic accept_c, clear_c, add_bias_c, wr_ok_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    clear_c    = 1'b0;
    add_bias_c = 1'b0;
    wr_ok_c    = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ok_c = w_we;
        if (start_signal) begin
          clear_c    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        accept_c = feature_valid;
        if (feature_valid && idx == IDX_W'(NUM_FEATURES - 1)) state_next = DRAIN;
      end
      DRAIN:  state_next = BIAS;
      BIAS: begin
        add_bias_c = 1'b1;
        state_next = OUTPUT;
      end
      OUTPUT: if (out_k == K_W'(NUM_NEURONS - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Parameter address decode: a contiguous weight window per neuron, then one bias each.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    localparam int unsigned LO = n * NUM_FEATURES;
    int   off;
    logic w_hit;
    logic b_hit;

    assign off   = int'(w_addr) - int'(LO);
    assign w_hit = wr_ok_c && (off >= 0) && (off < int'(NUM_FEATURES));
    assign b_hit = wr_ok_c && (w_addr == ADDR_W'(BIAS_BASE + n));

    fc_mac #(
      .NUM_FEATURES(NUM_FEATURES),
      .IDX_W       (IDX_W)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .w_we    (w_hit),
      .w_idx   (IDX_W'(off)),
      .w_data  (w_data[WEIGHT_W-1:0]),
      .b_we    (b_hit),
      .b_data  (w_data[BIAS_W-1:0]),
      .clear   (clear_c),
      .en      (accept_c),
      .idx     (idx),
      .feature (feature_in),
      .add_bias(add_bias_c),
      .acc     (acc[n])
    );
  end

  // Feature index, output sequencing, strict-greater argmax and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      out_k        <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      class_out    <= '0;
      class_valid  <= 1'b0;
      done_signal  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      class_valid  <= 1'b0;
      done_signal  <= 1'b0;
      if (clear_c)       idx <= '0;
      else if (accept_c) idx <= idx + IDX_W'(1);
      if (state == BIAS) out_k <= '0;
      if (state == OUTPUT) begin
        out_k        <= out_k + K_W'(1);
        result_out   <= acc[out_k];
        result_valid <= 1'b1;
        if (out_k == '0 || acc[out_k] > best_val) begin
          best_val <= acc[out_k];
          best_idx <= out_k;
        end
      end
      if (state == DONE) begin
        class_out   <= 2'(best_idx);
        class_valid <= 1'b1;
        done_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: hand-computed frame results, latency, reset abort and ignored inputs.
module tb_fc_layer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_signal;
  logic               feature_valid;
  logic signed [21:0] feature_in;
  logic               w_we;
  logic [9:0]         w_addr;
  logic [15:0]        w_data;
  logic signed [37:0] result_out;
  logic               result_valid;
  logic [1:0]         class_out;
  logic               class_valid;
  logic               done_signal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fc_layer dut (
    .clk          (clk),
    .rst          (rst),
    .start_signal (start_signal),
    .feature_valid(feature_valid),
    .feature_in   (feature_in),
    .w_we         (w_we),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .result_out   (result_out),
    .result_valid (result_valid),
    .class_out    (class_out),
    .class_valid  (class_valid),
    .done_signal  (done_signal)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = 10'(addr);
    w_data = 16'(data);
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    int wv[4];
    wv = '{w0, w1, w2, w3};
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 225; i++) wr(n * 225 + i, wv[n]);
  endtask

  task automatic set_biases(input int b0, input int b1, input int b2, input int b3);
    wr(900, b0);
    wr(901, b1);
    wr(902, b2);
    wr(903, b3);
  endtask

  // Feature k of the frame is base + inc*k; results are checked cycle-exactly after the last one.
  task automatic run_frame(input int base, input int inc, input bit gaps, input bit inject,
                           input bit extra, input longint e0, input longint e1,
                           input longint e2, input longint e3, input int ecls,
                           input string tag);
    longint ev[4];
    ev = '{e0, e1, e2, e3};
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
    for (int i = 0; i < 225; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      feature_valid = 1'b1;
      feature_in    = 22'(base + inc * i);
      if (inject && i == 50) begin
        start_signal = 1'b1;
        w_we   = 1'b1;
        w_addr = 10'd0;
        w_data = 16'd99;
      end
      @(negedge clk);
      feature_valid = 1'b0;
      start_signal  = 1'b0;
      w_we          = 1'b0;
    end
    for (int c = 1; c <= 10; c++) begin
      feature_valid = extra;
      feature_in    = 22'(7);
      @(posedge clk);
      #1;
      if (c <= 2) check($sformatf("%s_rv_early%0d", tag, c), longint'(result_valid), 0);
      if (c >= 3 && c <= 6) begin
        check($sformatf("%s_rv%0d", tag, c - 3), longint'(result_valid), 1);
        check($sformatf("%s_res%0d", tag, c - 3), result_out, ev[c - 3]);
      end
      if (c == 6) check($sformatf("%s_done_early", tag), longint'(done_signal), 0);
      if (c == 7) begin
        check($sformatf("%s_done", tag), longint'(done_signal), 1);
        check($sformatf("%s_cv", tag), longint'(class_valid), 1);
        check($sformatf("%s_class", tag), longint'(class_out), longint'(ecls));
        check($sformatf("%s_rv_off", tag), longint'(result_valid), 0);
        check($sformatf("%s_res_hold", tag), result_out, ev[3]);
      end
      if (c == 8) begin
        check($sformatf("%s_done_once", tag), longint'(done_signal), 0);
        check($sformatf("%s_class_hold", tag), longint'(class_out), longint'(ecls));
      end
      @(negedge clk);
    end
    feature_valid = 1'b0;
  endtask

  localparam longint S3 = -64'sd60397981568;

  initial begin
    rst           = 1'b1;
    start_signal  = 1'b0;
    feature_valid = 1'b0;
    feature_in    = '0;
    w_we          = 1'b0;
    w_addr        = '0;
    w_data        = '0;

    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_result", result_out, 0);
    check("rst_rv", longint'(result_valid), 0);
    check("rst_class", longint'(class_out), 0);
    check("rst_cv", longint'(class_valid), 0);
    check("rst_done", longint'(done_signal), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rv", longint'(result_valid), 0);
    check("post_rst_done", longint'(done_signal), 0);
    @(negedge clk);

    set_weights(1, 1, 1, 1);
    set_biases(0, 0, 0, 0);
    run_frame(1, 1, 0, 0, 0, 25425, 25425, 25425, 25425, 0, "s1");

    // Mid-frame start/write pulses and trailing features must not disturb anything.
    run_frame(1, 1, 0, 1, 1, 25425, 25425, 25425, 25425, 0, "s5");
    run_frame(1, 1, 0, 0, 0, 25425, 25425, 25425, 25425, 0, "s5_after");

    // Reset after 100 features aborts the frame with no output.
    start_signal = 1'b1;
    @(negedge clk);
    start_signal = 1'b0;
    for (int i = 0; i < 100; i++) begin
      feature_valid = 1'b1;
      feature_in    = 22'(i + 1);
      @(negedge clk);
    end
    feature_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 0 || c == 9) begin
        check($sformatf("s4_no_rv%0d", c), longint'(result_valid), 0);
        check($sformatf("s4_no_done%0d", c), longint'(done_signal), 0);
      end
      @(negedge clk);
    end
    run_frame(1, 1, 0, 0, 0, 25425, 25425, 25425, 25425, 0, "s4");

    set_weights(1, 1, 2, 1);
    set_biases(0, 0, 0, 5);
    run_frame(100, 0, 1, 0, 0, 22500, 22500, 45000, 22505, 2, "s2");

    set_weights(-128, -128, -128, -128);
    set_biases(-32768, -32768, -32768, -32768);
    run_frame(2097151, 0, 0, 0, 0, S3, S3, S3, S3, 0, "s3");

    set_weights(1, 1, 1, 1);
    set_biases(0, 0, 0, 0);
    run_frame(1, 1, 0, 0, 0, 25425, 25425, 25425, 25425, 0, "s6a");
    set_biases(1, 2, 3, 2);
    run_frame(0, 0, 0, 0, 0, 1, 2, 3, 2, 2, "s6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
